// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM controller: FSM state encodings, the default
// data-memory base address, generic enable constants and the byte-to-word helper.
package sram_controller_pkg;

  localparam int unsigned DEFAULT_BASE_ADDR = 1024;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    SRAM_IDLE = 2'd0,
    SRAM_LOW  = 2'd1,
    SRAM_HIGH = 2'd2,
    SRAM_DONE = 2'd3
  } sram_state_e;

  // Addresses below the base wrap modulo 2^32 before the shift.
  function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr,
                                               input logic [31:0] base_addr);
    return (byte_addr - base_addr) >> 2;
  endfunction

endpackage

// File: rtl/sram_controller.sv
// MEM-stage SRAM responder: splits each 32-bit load/store into two 16-bit
// accesses on an asynchronous SRAM, holding ready low until the word is done.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned BASE_ADDR     = DEFAULT_BASE_ADDR,
  parameter int unsigned SRAM_ADDR_W   = 18,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [15:0]            sram_dq,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic                   sram_ce_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n
);

  localparam logic [3:0] LastCnt = 4'(ACCESS_CYCLES - 1);

  sram_state_e            r_state;
  sram_state_e            w_state_next;
  logic [3:0]             r_cnt;
  logic [3:0]             w_cnt_next;
  logic                   r_is_write;
  logic [31:0]            r_wdata;
  logic [31:0]            r_read_data;
  logic [SRAM_ADDR_W-1:0] r_sram_addr;

  logic                   w_start;
  logic                   w_active;
  logic                   w_last;
  logic                   w_drive;
  logic [15:0]            w_wr_half;
  logic [SRAM_ADDR_W-2:0] w_word_lo;

  assign w_start   = (r_state == SRAM_IDLE) && (wr_en || rd_en);
  assign w_active  = (r_state == SRAM_LOW) || (r_state == SRAM_HIGH);
  assign w_last    = (r_cnt == LastCnt);
  assign w_word_lo = (SRAM_ADDR_W-1)'(byte_to_word(address, 32'(BASE_ADDR)));

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      SRAM_IDLE: begin
        if (w_start) begin
          w_state_next = SRAM_LOW;
          w_cnt_next   = 4'd0;
        end
      end
      SRAM_LOW: begin
        if (w_last) begin
          w_state_next = SRAM_HIGH;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      SRAM_HIGH: begin
        if (w_last) begin
          w_state_next = SRAM_DONE;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      SRAM_DONE: w_state_next = SRAM_IDLE;
      default:   w_state_next = SRAM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SRAM_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // The SRAM address is registered so it holds its last value between transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_write  <= 1'b0;
      r_wdata     <= 32'd0;
      r_sram_addr <= '0;
    end else if (w_start) begin
      r_is_write  <= wr_en;
      r_wdata     <= write_data;
      r_sram_addr <= {w_word_lo, 1'b0};
    end else if (r_state == SRAM_LOW && w_last) begin
      r_sram_addr[0] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read_data <= 32'd0;
    end else if (w_active && w_last && !r_is_write) begin
      if (r_state == SRAM_LOW) begin
        r_read_data[15:0] <= sram_dq;
      end else begin
        r_read_data[31:16] <= sram_dq;
      end
    end
  end

  assign w_drive   = (w_active && r_is_write) ? ENABLE : DISABLE;
  assign w_wr_half = (r_state == SRAM_HIGH) ? r_wdata[31:16] : r_wdata[15:0];
  assign sram_dq   = w_drive ? w_wr_half : 16'bz;

  // we_n rises on the last phase cycle so data is held past the write edge.
  assign sram_ce_n = ~w_active;
  assign sram_oe_n = ~(w_active & ~r_is_write);
  assign sram_we_n = ~(w_active & r_is_write & ~w_last);
  assign sram_ub_n = ~w_active;
  assign sram_lb_n = ~w_active;

  assign sram_addr = r_sram_addr;
  assign read_data = r_read_data;
  assign ready     = (r_state == SRAM_DONE) || ((r_state == SRAM_IDLE) && !wr_en && !rd_en);

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: behavioural SRAM on the pins plus a
// word-level reference memory, directed cases followed by randomized traffic.
module tb_sram_controller;

  localparam int unsigned A    = 2;
  localparam int unsigned SW   = 18;
  localparam int unsigned BASE = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [31:0]   address = 32'd0;
  logic [31:0]   write_data = 32'd0;
  logic [31:0]   read_data;
  logic          ready;
  wire  [15:0]   sram_dq;
  logic [SW-1:0] sram_addr;
  logic          sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  int checks = 0;
  int failures = 0;

  sram_controller #(
    .BASE_ADDR    (BASE),
    .SRAM_ADDR_W  (SW),
    .ACCESS_CYCLES(A)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .ready     (ready),
    .sram_dq   (sram_dq),
    .sram_addr (sram_addr),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n),
    .sram_ce_n (sram_ce_n),
    .sram_ub_n (sram_ub_n),
    .sram_lb_n (sram_lb_n)
  );

  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM: latch on rising we_n, drive while oe_n is low.
  logic [15:0] mem [0:(1<<SW)-1];
  initial for (int i = 0; i < (1 << SW); i++) mem[i] = 16'h0000;
  always @(posedge sram_we_n) if (!sram_ce_n) mem[sram_addr] <= sram_dq;
  assign sram_dq = (!sram_oe_n && !sram_ce_n && sram_we_n) ? mem[sram_addr] : 16'bz;

  // Word-level reference: index is the word number modulo the SRAM word count.
  logic [31:0] ref_mem [int];
  logic [31:0] exp_rd = 32'd0;

  function automatic int ref_idx(input logic [31:0] addr);
    logic [31:0] word;
    word = (addr - BASE) / 4;
    return int'(word % (1 << (SW - 1)));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_idle_strobes(input string tag);
    check_eq({tag, "_ce_n"}, 32'(sram_ce_n), 32'd1);
    check_eq({tag, "_oe_n"}, 32'(sram_oe_n), 32'd1);
    check_eq({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
    check_eq({tag, "_ub_lb"}, 32'({sram_ub_n, sram_lb_n}), 32'd3);
  endtask

  // One word transaction. Called with the bench just past a negedge; the
  // request is presented in the following IDLE cycle (edge 0 is the next posedge).
  task automatic run_txn(input bit is_wr, input bit both, input logic [31:0] addr,
                         input logic [31:0] data, input bit drop_early, input bit keep);
    logic [31:0] word;
    logic [SW-1:0] exp_lo;
    @(posedge clk); @(negedge clk);
    wr_en = is_wr; rd_en = !is_wr || both; address = addr; write_data = data;
    #1;
    check_eq("ready_req", 32'(ready), 32'd0);
    word   = (addr - BASE) / 4;
    exp_lo = SW'((word % (1 << (SW - 1))) * 2);
    for (int k = 1; k <= 2 * A + 1; k++) begin
      @(posedge clk); @(negedge clk);
      if (drop_early && k == 1) begin wr_en = 1'b0; rd_en = 1'b0; end
      #1;
      if (k <= 2 * A) check_eq("ready_busy", 32'(ready), 32'd0);
      if (k == 1 || k == A + 1) begin
        check_eq(k == 1 ? "addr_low" : "addr_high", 32'(sram_addr),
                 32'(exp_lo) + (k == 1 ? 32'd0 : 32'd1));
        check_eq("ce_n_phase", 32'(sram_ce_n), 32'd0);
        check_eq("oe_n_phase", 32'(sram_oe_n), is_wr ? 32'd1 : 32'd0);
        check_eq("we_n_phase", 32'(sram_we_n), is_wr ? 32'd0 : 32'd1);
        check_eq("ub_lb_phase", 32'({sram_ub_n, sram_lb_n}), 32'd0);
        if (is_wr) check_eq("dq_drive", 32'(sram_dq), k == 1 ? 32'(data[15:0]) : 32'(data[31:16]));
      end
      if (k == 2 * A + 1) begin
        check_eq("ready_done", 32'(ready), 32'd1);
        if (is_wr) begin
          ref_mem[ref_idx(addr)] = data;
        end else begin
          exp_rd = ref_mem.exists(ref_idx(addr)) ? ref_mem[ref_idx(addr)] : 32'd0;
        end
        check_eq(is_wr ? "rdata_kept" : "rdata_load", read_data, exp_rd);
        if (!keep) begin wr_en = 1'b0; rd_en = 1'b0; end
      end
    end
  endtask

  task automatic run_reset_mid(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b0; address = addr; write_data = data;
    for (int k = 1; k <= A + 1; k++) begin
      @(posedge clk); @(negedge clk);
    end
    #1;
    check_eq("rst_mid_in_high", 32'(sram_ce_n), 32'd0);
    rst = 1'b1; wr_en = 1'b0;
    #1;
    check_idle_strobes("rst_async");
    check_eq("rst_async_ready", 32'(ready), 32'd1);
    @(posedge clk); @(negedge clk);
    check_idle_strobes("rst_held");
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check_idle_strobes("rst_after");
    check_eq("rst_after_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    bit is_wr, both, drop, keep;
    logic [31:0] addr;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_rdata", read_data, 32'd0);
    check_eq("rst_addr", 32'(sram_addr), 32'd0);
    check_idle_strobes("rst");
    rst = 1'b0;

    run_txn(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 1'b0, 1'b0);
    check_eq("mem_lo_4", 32'(mem[4]), 32'h0000BEEF);
    check_eq("mem_hi_5", 32'(mem[5]), 32'h0000DEAD);
    run_txn(1'b0, 1'b0, 32'd1032, 32'd0, 1'b0, 1'b0);
    check_eq("rdata_direct", read_data, 32'hDEADBEEF);
    @(posedge clk); @(negedge clk);
    check_eq("rdata_hold", read_data, 32'hDEADBEEF);

    run_txn(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0, 1'b0);
    check_eq("both_mem0", 32'(mem[0]), 32'h00005678);
    check_eq("both_mem1", 32'(mem[1]), 32'h00001234);
    check_eq("both_rdata", read_data, 32'hDEADBEEF);

    run_txn(1'b1, 1'b0, 32'd1040, 32'hCAFEF00D, 1'b1, 1'b0);
    run_txn(1'b0, 1'b0, 32'd1040, 32'd0, 1'b0, 1'b0);
    check_eq("drop_readback", read_data, 32'hCAFEF00D);

    run_txn(1'b1, 1'b0, 32'd1020, 32'hA5A55A5A, 1'b0, 1'b0);
    check_eq("wrap_mem_lo", 32'(mem[(1 << SW) - 2]), 32'h00005A5A);
    run_txn(1'b0, 1'b0, 32'd1020, 32'd0, 1'b0, 1'b1);
    run_txn(1'b0, 1'b0, 32'd1032, 32'd0, 1'b0, 1'b0);
    check_eq("b2b_second", read_data, 32'hDEADBEEF);

    for (int n = 0; n < 40; n++) begin
      is_wr = 1'($urandom_range(0, 1));
      both  = 1'($urandom_range(0, 1));
      drop  = 1'($urandom_range(0, 1));
      keep  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) addr = $urandom() & 32'hFFFF_FFFC;
      else addr = BASE + 4 * $urandom_range(0, 31);
      run_txn(is_wr, both, addr, $urandom(), drop, keep);
    end
    wr_en = 1'b0; rd_en = 1'b0;

    run_reset_mid(32'd1200, 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
